delay_vec_rr_sched: RTL

Round-robin scheduler that shares one fixed-latency signed-vector delay pipeline among NREQ requesters. Each cycle it grants at most one valid requester, launches that requester's LENGTH-element vector into an internal DELAY-stage pipeline, and tags it with the requester index so the result emerges exactly DELAY cycles later with its source ID. A drain/quiesce state machine lets upstream control stop new launches and learn when the pipeline is empty, for example before a mode change.

---
 rtl/delay_vec_rr_sched_if.sv | 23 ++
 rtl/delay_vec_rr_sched.sv | 74 +++++++
 2 files changed

// File: rtl/delay_vec_rr_sched_if.sv
// delay_vec_rr_sched_if: requester, drain and result bundle of the shared delay pipeline
interface delay_vec_rr_sched_if #(
  parameter int DELAY  = 1,
  parameter int WIDTH  = 16,
  parameter int LENGTH = 4,
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ),
  parameter int CW     = $clog2(DELAY + 1)
);
  logic [NREQ-1:0]                         req_valid;
  logic [NREQ-1:0][LENGTH-1:0][WIDTH-1:0]  req_data;
  logic [NREQ-1:0]                         req_ready;
  logic                                    drain;
  logic                                    idle;
  logic                                    out_valid;
  logic [IDW-1:0]                          out_id;
  logic [LENGTH-1:0][WIDTH-1:0]            out_data;
  logic [CW-1:0]                           inflight;
  modport master (output req_valid, req_data, drain,
                  input  req_ready, idle, out_valid, out_id, out_data, inflight);
  modport slave  (input  req_valid, req_data, drain,
                  output req_ready, idle, out_valid, out_id, out_data, inflight);
endinterface

// File: rtl/delay_vec_rr_sched.sv
// delay_vec_rr_sched: round-robin launch of requester vectors into a tagged fixed-latency pipeline with drain/idle control
module delay_vec_rr_sched #(
  parameter int DELAY  = 1,
  parameter int WIDTH  = 16,
  parameter int LENGTH = 4,
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  delay_vec_rr_sched_if.slave bus
);
  localparam int CW = $clog2(DELAY + 1);
  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;
  typedef logic [LENGTH-1:0][WIDTH-1:0] vec_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, gidx, cand;
  logic [NREQ-1:0] gnt;
  logic launch;
  logic [DELAY-1:0] pv;
  logic [IDW-1:0] pid [DELAY];
  vec_t pd [DELAY];
  logic [CW-1:0] cnt;
  // scan downward so the candidate nearest ptr+1 is the one that sticks
  always_comb begin
    gidx = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      gidx = bus.req_valid[cand] ? cand : gidx;
    end
    gnt = (state == RUN && |bus.req_valid) ? NREQ'(1) << gidx : '0;
  end
  assign launch = |gnt;
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = bus.drain ? DRAIN : RUN;
      DRAIN:   state_nx = !bus.drain ? RUN : (cnt == '0 ? IDLE : DRAIN);
      IDLE:    state_nx = bus.drain ? IDLE : RUN;
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ptr   <= IDW'(NREQ - 1);
      cnt   <= '0;
      pv    <= '0;
      for (int s = 0; s < DELAY; s++) begin
        pid[s] <= '0;
        pd[s]  <= '0;
      end
    end else begin
      state <= state_nx;
      if (launch) ptr <= gidx;
      cnt   <= cnt + CW'(launch) - CW'(pv[DELAY-1]);
      pv[0]  <= launch;
      pid[0] <= launch ? gidx : '0;
      pd[0]  <= launch ? bus.req_data[gidx] : '0;
      for (int s = 1; s < DELAY; s++) begin
        pv[s]  <= pv[s-1];
        pid[s] <= pid[s-1];
        pd[s]  <= pd[s-1];
      end
    end
  end
  assign bus.req_ready = gnt;
  assign bus.out_valid = pv[DELAY-1];
  assign bus.out_id    = pid[DELAY-1];
  assign bus.out_data  = pd[DELAY-1];
  assign bus.inflight  = cnt;
  assign bus.idle      = state == IDLE;
endmodule
